axi_arbiter: RTL and testbench

AXI_ARBITER -- requirements
Module: axi_arbiter

---
 rtl/axi_arbiter.sv | 262 ++++++++++++++++++++++++++
 tb/tb_axi_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_arbiter.sv
// rtl/axi_arbiter.sv - IFU/LSU arbiter onto one AXI4 master port, one transaction at a time
// Define AXI_ARBITER_RR_EN for round-robin tie-breaking; default is fixed LSU priority.
`timescale 1ns/1ps
module axi_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   // IFU requester
   input  logic                  ifu_req_valid,
   output logic                  ifu_req_ready,
   input  logic [ADDR_W-1:0]     ifu_addr,
   output logic                  ifu_rsp_valid,
   output logic [DATA_W-1:0]     ifu_rdata,
   output logic                  ifu_rsp_err,
   // LSU requester
   input  logic                  lsu_req_valid,
   output logic                  lsu_req_ready,
   input  logic                  lsu_wen,
   input  logic [ADDR_W-1:0]     lsu_addr,
   input  logic [DATA_W-1:0]     lsu_wdata,
   input  logic [DATA_W/8-1:0]   lsu_wstrb,
   input  logic [2:0]            lsu_size,
   output logic                  lsu_rsp_valid,
   output logic [DATA_W-1:0]     lsu_rdata,
   output logic                  lsu_rsp_err,
   // AXI4 master: write address
   input  logic                  io_master_awready,
   output logic                  io_master_awvalid,
   output logic [ADDR_W-1:0]     io_master_awaddr,
   output logic [3:0]            io_master_awid,
   output logic [7:0]            io_master_awlen,
   output logic [2:0]            io_master_awsize,
   output logic [1:0]            io_master_awburst,
   // AXI4 master: write data
   input  logic                  io_master_wready,
   output logic                  io_master_wvalid,
   output logic [DATA_W-1:0]     io_master_wdata,
   output logic [DATA_W/8-1:0]   io_master_wstrb,
   output logic                  io_master_wlast,
   // AXI4 master: write response
   output logic                  io_master_bready,
   input  logic                  io_master_bvalid,
   input  logic [1:0]            io_master_bresp,
   // AXI4 master: read address
   input  logic                  io_master_arready,
   output logic                  io_master_arvalid,
   output logic [ADDR_W-1:0]     io_master_araddr,
   output logic [3:0]            io_master_arid,
   output logic [7:0]            io_master_arlen,
   output logic [2:0]            io_master_arsize,
   output logic [1:0]            io_master_arburst,
   // AXI4 master: read data
   output logic                  io_master_rready,
   input  logic                  io_master_rvalid,
   input  logic [1:0]            io_master_rresp,
   input  logic [DATA_W-1:0]     io_master_rdata
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_AR   = 3'd1,
      RD_R    = 3'd2,
      WR_AW_W = 3'd3,
      WR_B    = 3'd4,
      RESP    = 3'd5
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
   logic [2:0]            size_q, size_d;
   logic [1:0]            resp_q, resp_d;
   logic                  wen_q, wen_d;
   logic                  owner_q, owner_d;      // 1 = LSU owns the transaction
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;

   logic                  lsu_prio;
   logic                  lsu_sel;
   logic                  lsu_grant;
   logic                  ifu_grant;
   logic                  lsu_misaligned;
   logic                  aw_hs;
   logic                  w_hs;

`ifdef AXI_ARBITER_RR_EN
   logic                  last_grant_q, last_grant_d;   // 1 = LSU got the most recent grant

   assign lsu_prio     = ~last_grant_q;
   assign last_grant_d = lsu_grant ? 1'b1 : (ifu_grant ? 1'b0 : last_grant_q);

   always_ff @(posedge clock) begin
      if (!reset) begin
         last_grant_q <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`else
   assign lsu_prio = 1'b1;
`endif

   // Ready is a pure function of the pending requests so only the winner sees it.
   assign lsu_sel       = lsu_req_valid & (lsu_prio | ~ifu_req_valid);
   assign lsu_req_ready = reset & (state_q == IDLE) & lsu_sel;
   assign ifu_req_ready = reset & (state_q == IDLE) & ifu_req_valid & ~lsu_sel;
   assign lsu_grant     = lsu_req_valid & lsu_req_ready;
   assign ifu_grant     = ifu_req_valid & ifu_req_ready;

   assign lsu_misaligned = ((lsu_size == 3'b010) && (lsu_addr[1:0] != 2'b00)) ||
                           ((lsu_size == 3'b001) && lsu_addr[0]);

   assign aw_hs = io_master_awvalid & io_master_awready;
   assign w_hs  = io_master_wvalid & io_master_wready;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      wstrb_d   = wstrb_q;
      size_d    = size_q;
      resp_d    = resp_q;
      wen_d     = wen_q;
      owner_d   = owner_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;

      case (state_q)
         IDLE: begin
            if (lsu_grant) begin
               addr_d    = lsu_addr;
               wdata_d   = lsu_wdata;
               wstrb_d   = lsu_wstrb;
               size_d    = lsu_size;
               wen_d     = lsu_wen;
               owner_d   = 1'b1;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               rdata_d   = '0;
               resp_d    = 2'b00;
               if (lsu_misaligned) begin
                  resp_d  = 2'b10;
                  state_d = RESP;
               end else if (lsu_wen) begin
                  state_d = WR_AW_W;
               end else begin
                  state_d = RD_AR;
               end
            end else if (ifu_grant) begin
               addr_d    = ifu_addr;
               wdata_d   = '0;
               wstrb_d   = '0;
               size_d    = 3'b010;
               wen_d     = 1'b0;
               owner_d   = 1'b0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               rdata_d   = '0;
               resp_d    = 2'b00;
               state_d   = RD_AR;
            end
         end
         RD_AR: begin
            if (io_master_arready) begin
               state_d = RD_R;
            end
         end
         RD_R: begin
            if (io_master_rvalid) begin
               rdata_d = io_master_rdata;
               resp_d  = io_master_rresp;
               state_d = RESP;
            end
         end
         WR_AW_W: begin
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
            if (aw_done_d && w_done_d) begin
               state_d = WR_B;
            end
         end
         WR_B: begin
            if (io_master_bvalid) begin
               resp_d  = io_master_bresp;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         wstrb_q   <= '0;
         size_q    <= '0;
         resp_q    <= '0;
         wen_q     <= 1'b0;
         owner_q   <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         wstrb_q   <= wstrb_d;
         size_q    <= size_d;
         resp_q    <= resp_d;
         wen_q     <= wen_d;
         owner_q   <= owner_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign io_master_awvalid = (state_q == WR_AW_W) & ~aw_done_q;
   assign io_master_awaddr  = addr_q;
   assign io_master_awid    = 4'd0;
   assign io_master_awlen   = 8'd0;
   assign io_master_awsize  = size_q;
   assign io_master_awburst = 2'b01;

   // Byte lanes follow the low address bits; strobes shifted past the bus width fall off.
   assign io_master_wvalid  = (state_q == WR_AW_W) & ~w_done_q;
   assign io_master_wdata   = wdata_q << {addr_q[1:0], 3'b000};
   assign io_master_wstrb   = wstrb_q << addr_q[1:0];
   assign io_master_wlast   = io_master_wvalid;

   assign io_master_bready  = (state_q == WR_B);

   assign io_master_arvalid = (state_q == RD_AR);
   assign io_master_araddr  = addr_q;
   assign io_master_arid    = 4'd0;
   assign io_master_arlen   = 8'd0;
   assign io_master_arsize  = size_q;
   assign io_master_arburst = 2'b01;

   assign io_master_rready  = (state_q == RD_R);

   assign ifu_rsp_valid = (state_q == RESP) & ~owner_q;
   assign ifu_rdata     = rdata_q;
   assign ifu_rsp_err   = (resp_q != 2'b00);

   assign lsu_rsp_valid = (state_q == RESP) & owner_q;
   assign lsu_rdata     = wen_q ? '0 : (rdata_q >> {addr_q[1:0], 3'b000});
   assign lsu_rsp_err   = (resp_q != 2'b00);

endmodule

// File: tb/tb_axi_arbiter.sv
// tb/tb_axi_arbiter.sv - self-checking bench for axi_arbiter
// Table-driven transactions against a reactive slave, with a response scoreboard.
`timescale 1ns/1ps
module tb_axi_arbiter;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wstrb;
   logic [2:0]  lsu_size;
   logic        io_master_awready, io_master_awvalid;
   logic [31:0] io_master_awaddr;
   logic [3:0]  io_master_awid;
   logic [7:0]  io_master_awlen;
   logic [2:0]  io_master_awsize;
   logic [1:0]  io_master_awburst;
   logic        io_master_wready, io_master_wvalid, io_master_wlast;
   logic [31:0] io_master_wdata;
   logic [3:0]  io_master_wstrb;
   logic        io_master_bready, io_master_bvalid;
   logic [1:0]  io_master_bresp;
   logic        io_master_arready, io_master_arvalid;
   logic [31:0] io_master_araddr;
   logic [3:0]  io_master_arid;
   logic [7:0]  io_master_arlen;
   logic [2:0]  io_master_arsize;
   logic [1:0]  io_master_arburst;
   logic        io_master_rready, io_master_rvalid;
   logic [1:0]  io_master_rresp;
   logic [31:0] io_master_rdata;

   axi_arbiter dut (
      .clock(clock), .reset(reset),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
      .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_size(lsu_size),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata), .lsu_rsp_err(lsu_rsp_err),
      .io_master_awready(io_master_awready), .io_master_awvalid(io_master_awvalid),
      .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid),
      .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
      .io_master_awburst(io_master_awburst),
      .io_master_wready(io_master_wready), .io_master_wvalid(io_master_wvalid),
      .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
      .io_master_wlast(io_master_wlast),
      .io_master_bready(io_master_bready), .io_master_bvalid(io_master_bvalid),
      .io_master_bresp(io_master_bresp),
      .io_master_arready(io_master_arready), .io_master_arvalid(io_master_arvalid),
      .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
      .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
      .io_master_arburst(io_master_arburst),
      .io_master_rready(io_master_rready), .io_master_rvalid(io_master_rvalid),
      .io_master_rresp(io_master_rresp), .io_master_rdata(io_master_rdata)
   );

   // Slave configuration, written only by the test process
   logic [31:0] cfg_rdata = 32'd0;
   logic [1:0]  cfg_rresp = 2'd0;
   logic [1:0]  cfg_bresp = 2'd0;
   int          aw_stall_cfg = 0;
   logic        hold_r = 1'b0;
   logic        force_rvalid = 1'b0;

   // Zero-wait reactive slave; AW can be stalled for aw_stall_cfg cycles
   initial begin
      int aw_cnt;
      aw_cnt = 0;
      io_master_awready = 1'b0; io_master_wready = 1'b0; io_master_bvalid = 1'b0;
      io_master_bresp = 2'b00; io_master_arready = 1'b0; io_master_rvalid = 1'b0;
      io_master_rresp = 2'b00; io_master_rdata = 32'd0;
      forever begin
         @(negedge clock);
         io_master_arready = 1'b1;
         io_master_wready  = 1'b1;
         io_master_rvalid  = (io_master_rready & ~hold_r) | force_rvalid;
         io_master_rdata   = cfg_rdata;
         io_master_rresp   = cfg_rresp;
         io_master_bvalid  = io_master_bready;
         io_master_bresp   = cfg_bresp;
         if (io_master_awvalid && aw_cnt < aw_stall_cfg) begin
            io_master_awready = 1'b0;
            aw_cnt++;
         end else begin
            io_master_awready = 1'b1;
            if (!io_master_awvalid) aw_cnt = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        lsu;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          gcyc;
   } sb_t;

   typedef struct {
      logic        lsu;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [2:0]  size;
      logic [31:0] s_rdata;
      logic [1:0]  s_resp;
      logic        e_bus;
      logic [2:0]  e_size;
      logic [31:0] e_wdata;
      logic [3:0]  e_wstrb;
      logic [31:0] e_rdata;
      logic        e_err;
      int          e_lat;
   } vec_t;

   sb_t         sb[$];
   vec_t        vecs[9];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        ar_seen, aw_seen;
   logic [31:0] cap_addr, cap_wdata;
   logic [2:0]  cap_size;
   logic [3:0]  cap_wstrb;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Every wait goes through here: bus capture, protocol checks and scoreboard pops
   task automatic tick();
      sb_t e;
      @(negedge clock);
      cyc++;
      if (io_master_arvalid) begin
         ar_seen  = 1'b1;
         cap_addr = io_master_araddr;
         cap_size = io_master_arsize;
         chk("ar_const", 64'({io_master_arid, io_master_arlen, io_master_arburst}), 64'({4'd0, 8'd0, 2'b01}));
      end
      if (io_master_awvalid) begin
         aw_seen  = 1'b1;
         cap_addr = io_master_awaddr;
         cap_size = io_master_awsize;
         chk("aw_const", 64'({io_master_awid, io_master_awlen, io_master_awburst}), 64'({4'd0, 8'd0, 2'b01}));
      end
      if (io_master_wvalid) begin
         cap_wdata = io_master_wdata;
         cap_wstrb = io_master_wstrb;
         chk("wlast", 64'(io_master_wlast), 64'(1));
      end
      chk("one_ready", 64'(ifu_req_ready & lsu_req_ready), 64'(0));
      if (ifu_rsp_valid | lsu_rsp_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: ifu_rsp_valid=%0b lsu_rsp_valid=%0b, expected none", ifu_rsp_valid, lsu_rsp_valid);
         end else begin
            e = sb.pop_front();
            chk("rsp_port", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'({~e.lsu, e.lsu}));
            chk("rsp_rdata", 64'(e.lsu ? lsu_rdata : ifu_rdata), 64'(e.rdata));
            chk("rsp_err", 64'(e.lsu ? lsu_rsp_err : ifu_rsp_err), 64'(e.err));
            if (e.lat != 0) chk("rsp_latency", 64'(cyc - e.gcyc), 64'(e.lat));
         end
      end
   endtask

   task automatic issue(input logic lsu, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb, input logic [2:0] size,
                        input logic [31:0] e_rdata, input logic e_err, input int e_lat);
      logic got;
      got = 1'b0;
      ar_seen = 1'b0;
      aw_seen = 1'b0;
      if (lsu) begin
         lsu_req_valid = 1'b1; lsu_wen = wen; lsu_addr = addr;
         lsu_wdata = wdata; lsu_wstrb = wstrb; lsu_size = size;
      end else begin
         ifu_req_valid = 1'b1; ifu_addr = addr;
      end
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         if (lsu ? lsu_req_ready : ifu_req_ready) begin
            got = 1'b1;
            sb.push_back('{lsu, e_rdata, e_err, e_lat, cyc});
         end
         tick();
      end
      lsu_req_valid = 1'b0;
      ifu_req_valid = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL grant_timeout: no ready within 20 cycles, expected a grant");
      end
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound && sb.size() > 0; i++) tick();
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", sb.size());
         sb.delete();
      end
      tick();
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      sb.delete();
      tick();
      tick();
      reset = 1'b1;
   endtask

   function automatic logic exp_tie_lsu(input int g);
`ifdef AXI_ARBITER_RR_EN
      return (g % 2) == 0;
`else
      return 1'b1;
`endif
   endfunction

   initial begin
      logic got;
      vecs[0] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 3'd0, 32'h0000_0413, 2'b00, 1'b1, 3'd2, 32'h0, 4'h0, 32'h0000_0413, 1'b0, 3};
      vecs[1] = '{1'b1, 1'b0, 32'h8000_0006, 32'h0, 4'h0, 3'd1, 32'h1234_5678, 2'b10, 1'b1, 3'd1, 32'h0, 4'h0, 32'h0000_1234, 1'b1, 3};
      vecs[2] = '{1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 3'd2, 32'h0, 2'b00, 1'b1, 3'd2, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 3};
      vecs[3] = '{1'b1, 1'b0, 32'h8000_0001, 32'h0, 4'h0, 3'd0, 32'hAABB_CCDD, 2'b00, 1'b1, 3'd0, 32'h0, 4'h0, 32'h00AA_BBCC, 1'b0, 3};
      vecs[4] = '{1'b1, 1'b1, 32'h8000_0002, 32'h0000_BEEF, 4'h3, 3'd1, 32'h0, 2'b11, 1'b1, 3'd1, 32'hBEEF_0000, 4'hC, 32'h0, 1'b1, 3};
      vecs[5] = '{1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 3'd0, 32'hCAFE_F00D, 2'b01, 1'b1, 3'd2, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1, 3};
      vecs[6] = '{1'b1, 1'b0, 32'h8000_0002, 32'h0, 4'h0, 3'd2, 32'h9999_9999, 2'b00, 1'b0, 3'd0, 32'h0, 4'h0, 32'h0, 1'b1, 1};
      vecs[7] = '{1'b1, 1'b1, 32'h8000_0003, 32'h0000_1234, 4'h3, 3'd1, 32'h0, 2'b00, 1'b0, 3'd0, 32'h0, 4'h0, 32'h0, 1'b1, 1};
      vecs[8] = '{1'b0, 1'b0, 32'h8000_0003, 32'h0, 4'h0, 3'd0, 32'h1122_3344, 2'b00, 1'b1, 3'd2, 32'h0, 4'h0, 32'h1122_3344, 1'b0, 3};

      reset = 1'b0;
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
      lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = 32'd0;
      lsu_wdata = 32'd0; lsu_wstrb = 4'd0; lsu_size = 3'd0;
      tick();
      tick();
      chk("rst_ifu_ready", 64'(ifu_req_ready), 64'(0));
      chk("rst_bus_valids", 64'({io_master_arvalid, io_master_awvalid, io_master_wvalid,
                                 io_master_rready, io_master_bready}), 64'(0));
      chk("rst_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err}), 64'(0));
      chk("rst_rdata", 64'({ifu_rdata, lsu_rdata}), 64'(0));
      ifu_req_valid = 1'b0;
      reset = 1'b1;
      tick();

      for (int v = 0; v < 9; v++) begin
         cfg_rdata = vecs[v].s_rdata;
         cfg_rresp = vecs[v].s_resp;
         cfg_bresp = vecs[v].s_resp;
         issue(vecs[v].lsu, vecs[v].wen, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb,
               vecs[v].size, vecs[v].e_rdata, vecs[v].e_err, vecs[v].e_lat);
         drain(20);
         chk($sformatf("v%0d_bus_seen", v), 64'(ar_seen | aw_seen), 64'(vecs[v].e_bus));
         if (vecs[v].e_bus) begin
            chk($sformatf("v%0d_dir", v), 64'(aw_seen), 64'(vecs[v].wen));
            chk($sformatf("v%0d_addr", v), 64'(cap_addr), 64'(vecs[v].addr));
            chk($sformatf("v%0d_size", v), 64'(cap_size), 64'(vecs[v].e_size));
            if (vecs[v].wen) begin
               chk($sformatf("v%0d_wdata", v), 64'(cap_wdata), 64'(vecs[v].e_wdata));
               chk($sformatf("v%0d_wstrb", v), 64'(cap_wstrb), 64'(vecs[v].e_wstrb));
            end
         end
      end

      // Byte write with AW stalled two cycles while W is accepted at once
      aw_stall_cfg = 2;
      cfg_bresp = 2'b00;
      issue(1'b1, 1'b1, 32'h8000_0003, 32'h0000_00AB, 4'b0001, 3'd0, 32'h0, 1'b0, 5);
      chk("bw_valids_n1", 64'({io_master_awvalid, io_master_wvalid}), 64'(2'b11));
      chk("bw_wdata", 64'(io_master_wdata), 64'(32'hAB00_0000));
      chk("bw_wstrb", 64'(io_master_wstrb), 64'(4'b1000));
      tick();
      chk("bw_n2", 64'({io_master_awvalid, io_master_wvalid, io_master_bready}), 64'(3'b100));
      tick();
      chk("bw_n3", 64'({io_master_awvalid, io_master_wvalid, io_master_bready}), 64'(3'b100));
      tick();
      chk("bw_n4", 64'({io_master_awvalid, io_master_wvalid, io_master_bready}), 64'(3'b001));
      drain(20);
      aw_stall_cfg = 0;

      // Four back-to-back ties
      do_reset();
      cfg_rdata = 32'h0000_0055;
      cfg_rresp = 2'b00;
      lsu_wen = 1'b0; lsu_addr = 32'h8000_0100; lsu_size = 3'd2;
      ifu_addr = 32'h8000_0200;
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      for (int g = 0; g < 4; g++) begin
         got = 1'b0;
         for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (ifu_req_ready | lsu_req_ready) begin
               got = 1'b1;
               chk($sformatf("tie_grant%0d", g), 64'(lsu_req_ready), 64'(exp_tie_lsu(g)));
               sb.push_back('{exp_tie_lsu(g), 32'h0000_0055, 1'b0, 3, cyc});
            end
            tick();
         end
         if (!got) begin
            checks++;
            errors++;
            $display("FAIL tie_timeout%0d: no grant within 20 cycles, expected one", g);
         end
      end
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      drain(20);

      // Reset during RD_R, then a late beat from the slave
      hold_r = 1'b1;
      issue(1'b1, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 3'd2, 32'h0, 1'b0, 0);
      tick();
      chk("mid_rready", 64'(io_master_rready), 64'(1));
      reset = 1'b0;
      sb.delete();
      tick();
      reset = 1'b1;
      cfg_rdata = 32'hDEAD_BEEF;
      force_rvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_bus", 64'({io_master_arvalid, io_master_awvalid, io_master_wvalid,
                               io_master_rready, io_master_bready}), 64'(0));
         chk("abort_rsp", 64'({ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err}), 64'(0));
         chk("abort_rdata", 64'({ifu_rdata, lsu_rdata}), 64'(0));
      end
      force_rvalid = 1'b0;
      hold_r = 1'b0;
      tick();
      lsu_req_valid = 1'b1;
      #1;
      chk("abort_idle_ready", 64'(lsu_req_ready), 64'(1));
      lsu_req_valid = 1'b0;
      tick();
      cfg_rdata = 32'h0000_0013;
      issue(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 3'd0, 32'h0000_0013, 1'b0, 3);
      drain(20);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
